// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush with bubble insertion and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {m_valid, s_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic m_valid;
  logic s_valid;
  logic in_fire;
  logic out_fire;

  assign m_valid = state_q[1];
  assign s_valid = state_q[0];

  // With SKID the ready depends only on a flop, breaking the out_ready path.
  assign in_ready  = SKID ? ~s_valid : (out_ready | ~m_valid);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid ? m_ctrl_q : '0;
  assign stall_cnt = cnt_q;

  // NOTE: every signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      state_d  = ST_EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire && SKID) begin
            state_d  = ST_TWO;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_ctrl_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: payload registers are reset too, so out_data reads 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so all state updates see the pre-edge values.
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, single register, 4-bit counter)
// checked every cycle against a FIFO-occupancy model plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [DW-1:0] in_data   [3];
  logic [CW-1:0] in_ctrl   [3];
  logic          flush     [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [DW-1:0] out_data  [3];
  logic [CW-1:0] out_ctrl  [3];
  logic [15:0]   stall_cnt [3];
  logic [3:0]    sat_cnt;

  assign stall_cnt[2] = {12'd0, sat_cnt};

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
    .stall_cnt(stall_cnt[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(16)) u_reg (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
    .stall_cnt(stall_cnt[1])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_ctrl(in_ctrl[2]),
    .flush(flush[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_ctrl(out_ctrl[2]),
    .stall_cnt(sat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (plain register).
  bit            sk_mode [3] = '{1'b1, 1'b0, 1'b1};
  int            sat_max [3] = '{65535, 65535, 15};
  int            mcnt    [3] = '{0, 0, 0};
  int            mstall  [3] = '{0, 0, 0};
  logic [DW-1:0] mq_d    [3][2];
  logic [CW-1:0] mq_c    [3][2];

  function automatic bit model_ready(input int k);
    return sk_mode[k] ? (mcnt[k] < 2) : (out_ready[k] || mcnt[k] == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    bit inf, outf;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        mcnt[k]   = 0;
        mstall[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        inf  = in_valid[k] && model_ready(k);
        outf = (mcnt[k] > 0) && out_ready[k];
        if (mcnt[k] > 0 && !out_ready[k] && mstall[k] < sat_max[k]) mstall[k]++;
        if (flush[k]) begin
          mcnt[k] = 0;
        end else begin
          if (outf) begin
            mq_d[k][0] = mq_d[k][1];
            mq_c[k][0] = mq_c[k][1];
            mcnt[k]--;
          end
          if (inf) begin
            mq_d[k][mcnt[k]] = in_data[k];
            mq_c[k][mcnt[k]] = in_ctrl[k];
            mcnt[k]++;
          end
        end
      end
    end
  end

  // Delivered-word log, captured mid-cycle when a transfer is about to complete.
  logic [DW-1:0] log_d [3][64];
  int            log_n [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(model_ready(k)));
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mcnt[k] > 0));
        check($sformatf("out_ctrl[%0d]", k), 64'(out_ctrl[k]),
              (mcnt[k] > 0) ? 64'(mq_c[k][0]) : 64'd0);
        if (mcnt[k] > 0)
          check($sformatf("out_data[%0d]", k), 64'(out_data[k]), 64'(mq_d[k][0]));
        check($sformatf("stall_cnt[%0d]", k), 64'(stall_cnt[k]), 64'(mstall[k]));
        if (out_valid[k] && out_ready[k] && log_n[k] < 64) begin
          log_d[k][log_n[k]] = out_data[k];
          log_n[k]++;
        end
      end
    end
  end

  // One cycle: inputs applied just after a rising edge, returns just after the next.
  task automatic step(input int k, input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit ordy, input bit fl, output bit fired);
    in_valid[k]  = iv;
    in_data[k]   = d;
    in_ctrl[k]   = c;
    out_ready[k] = ordy;
    flush[k]     = fl;
    @(negedge clk);
    fired = iv && in_ready[k];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int base;
    int w;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_ctrl[k] = '0;
      flush[k] = 1'b0; out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid[0]), 64'd0);
    check("reset out_data", 64'(out_data[0]), 64'd0);
    check("reset out_ctrl", 64'(out_ctrl[0]), 64'd0);
    check("reset in_ready", 64'(in_ready[0]), 64'd1);
    check("reset stall_cnt", 64'(stall_cnt[0]), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming 1..10 through the skid stage at full rate.
    for (int i = 1; i <= 10; i++) begin
      step(0, 1'b1, DW'(i), CW'(i), 1'b1, 1'b0, f);
      check($sformatf("stream word %0d", i), 64'(out_data[0]), 64'(i));
      check($sformatf("stream in_ready %0d", i), 64'(in_ready[0]), 64'd1);
    end
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, f);
    check("stream count", 64'(log_n[0]), 64'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("stream order %0d", i), 64'(log_d[0][i]), 64'(i + 1));

    // Back-pressure: A on output, B lands in skid, C waits upstream.
    base = log_n[0];
    step(0, 1'b1, 32'hA, 8'h01, 1'b1, 1'b0, f);
    step(0, 1'b1, 32'hB, 8'h02, 1'b0, 1'b0, f);
    check("bp in_ready stall1", 64'(in_ready[0]), 64'd0);
    step(0, 1'b1, 32'hC, 8'h03, 1'b0, 1'b0, f);
    check("bp in_ready stall2", 64'(in_ready[0]), 64'd0);
    step(0, 1'b1, 32'hC, 8'h03, 1'b0, 1'b0, f);
    check("bp in_ready stall3", 64'(in_ready[0]), 64'd0);
    check("bp stall_cnt", 64'(stall_cnt[0]), 64'd3);
    check("bp head held", 64'(out_data[0]), 64'hA);
    step(0, 1'b1, 32'hC, 8'h03, 1'b1, 1'b0, f);
    check("bp in_ready reopen", 64'(in_ready[0]), 64'd1);
    step(0, 1'b1, 32'hC, 8'h03, 1'b1, 1'b0, f);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, f);
    check("bp delivered", 64'(log_n[0] - base), 64'd3);
    check("bp order A", 64'(log_d[0][base]), 64'hA);
    check("bp order B", 64'(log_d[0][base + 1]), 64'hB);
    check("bp order C", 64'(log_d[0][base + 2]), 64'hC);

    // Flush from TWO with offered 0x55, then flush discarding an accepted word.
    base = log_n[0];
    step(0, 1'b1, 32'h11, 8'hFF, 1'b0, 1'b0, f);
    step(0, 1'b1, 32'h22, 8'hFF, 1'b0, 1'b0, f);
    check("flush pre in_ready", 64'(in_ready[0]), 64'd0);
    step(0, 1'b1, 32'h55, 8'hFF, 1'b0, 1'b1, f);
    check("flush out_valid", 64'(out_valid[0]), 64'd0);
    check("flush out_ctrl", 64'(out_ctrl[0]), 64'd0);
    check("flush in_ready", 64'(in_ready[0]), 64'd1);
    step(0, 1'b1, 32'h66, 8'h0F, 1'b0, 1'b0, f);
    step(0, 1'b1, 32'h77, 8'hF0, 1'b0, 1'b1, f);
    check("flush fire out_valid", 64'(out_valid[0]), 64'd0);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, f);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, f);
    check("flush nothing delivered", 64'(log_n[0]), 64'(base));
    check("flush keeps stall_cnt", 64'(stall_cnt[0]), 64'd6);

    // Plain register mode with out_ready toggling every cycle.
    w = 1;
    for (int c = 0; c < 40 && w <= 6; c++) begin
      step(1, 1'b1, 32'h100 + DW'(w), CW'(w), c[0] == 1'b0, 1'b0, f);
      if (f) w++;
    end
    check("reg words accepted", 64'(w), 64'd7);
    step(1, 1'b0, '0, '0, 1'b1, 1'b0, f);
    step(1, 1'b0, '0, '0, 1'b1, 1'b0, f);
    check("reg delivered", 64'(log_n[1]), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("reg order %0d", i), 64'(log_d[1][i]), 64'(32'h101 + i));

    // Saturation of the 4-bit counter over 20 stalled cycles.
    step(2, 1'b1, 32'h5A, 8'h3C, 1'b0, 1'b0, f);
    repeat (20) step(2, 1'b0, '0, '0, 1'b0, 1'b0, f);
    check("sat stall_cnt", 64'(sat_cnt), 64'd15);
    check("sat data held", 64'(out_data[2]), 64'h5A);
    check("sat valid before reset", 64'(out_valid[2]), 64'd1);

    // Asynchronous reset mid-stream, observed before the next clock edge.
    reset = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid[2]), 64'd0);
    check("async out_ctrl", 64'(out_ctrl[2]), 64'd0);
    check("async out_data", 64'(out_data[2]), 64'd0);
    check("async stall_cnt", 64'(sat_cnt), 64'd0);
    check("async in_ready", 64'(in_ready[2]), 64'd1);
    check("async stall_cnt skid", 64'(stall_cnt[0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the CPU datapath. It generalises the fixed-width, stall-only inter-stage latches into one block with configurable width, a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush with bubble insertion and a stall-cycle counter. Instances sit between IF/ID, ID/EXMEM and EXMEM/WB. Control fields (write/memory enables) are zeroed on any bubble.

## Interface
Parameters:
- DATA_W, 128, width of the payload (register data, immediates, addresses).
- CTRL_W, 8, width of the control fields (wrEn, memEn, memwrEn, forward bits…). These are forced to 0 whenever the output is not valid.
- SKID, 1, selects the buffering mode. 1 = 2-entry skid buffer with a registered in_ready. 0 = single register with a combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-low. 0 = in reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept an instruction.
- in_data  in  [0:DATA_W-1]  upstream payload.
- in_ctrl  in  [0:CTRL_W-1]  upstream control fields.
- flush  in  1  synchronous kill of all held contents.
- out_valid  out  1  out_data/out_ctrl hold a valid instruction.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  [0:DATA_W-1]  payload to the next stage.
- out_ctrl  out  [0:CTRL_W-1]  control fields; 0 when out_valid=0.
- stall_cnt  out  [0:CNT_W-1]  saturating count of back-pressured cycles.

## Operation
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main register (m_valid, m_data, m_ctrl) drives the outputs.
  - skid register (s_valid, s_data, s_ctrl) exists only when SKID=1.
- State (SKID=1), encoded by {m_valid, s_valid}: EMPTY(00), ONE(10), TWO(11). State 01 is illegal.
  - EMPTY: in_fire → ONE, main ← in.
  - ONE:
    - in_fire & out_fire → ONE, main ← in.
    - in_fire & !out_fire → TWO, skid ← in.
    - !in_fire & out_fire → EMPTY.
    - otherwise hold.
  - TWO:
    - out_fire → ONE, main ← skid, skid cleared.
    - otherwise hold.
  - in_ready = !s_valid. It is registered, so there is no combinational path from out_ready.
- SKID=0:
  - in_ready = out_ready | !m_valid (combinational).
  - in_fire loads main.
  - out_fire without in_fire clears m_valid.
- Flush has the highest priority.
  - Next cycle: m_valid=0, s_valid=0, m_ctrl=0, s_ctrl=0, state EMPTY.
  - An in_fire in the flush cycle is discarded. The input is consumed, not retained.
  - Data registers are not cleared; only valid and ctrl are.
- Bubble rule: out_ctrl = m_valid ? m_ctrl : 0. A stalled or empty stage never asserts write or memory enables downstream.
- Ordering is FIFO; no reordering and no duplication.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset (asynchronous assertion, sampled release): out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, s_valid=0, in_ready=1.
- A reset pulse in any state returns the block to EMPTY immediately, without waiting for a clock edge.
- Latency is 1 cycle: data accepted at edge N is visible on out_data after edge N.
- Throughput is 1 transfer per cycle when out_ready is held at 1.
- SKID=1, back-pressure:
  - out_ready drops at cycle N: the stage absorbs at most one more instruction (into skid).
  - in_ready falls after the edge that fills skid.
  - in_ready rises 1 cycle after out_fire drains TWO → ONE.
- Simultaneous in_fire and out_fire in ONE: the word passes through, with no bubble and no skid use.
- in_valid may be asserted without in_ready, but upstream must hold in_data/in_ctrl stable until in_fire.

## Test plan
- Reset and idle:
  - Stimulus: drive reset=0 mid-stream with m_valid=1.
  - Required: out_valid=0, out_ctrl=0, stall_cnt=0 and in_ready=1 immediately, before the next clk edge.
- Streaming:
  - Stimulus: SKID=1, out_ready=1, in_valid=1 with in_data=1,2,3…10 on consecutive cycles.
  - Required: out_data=1..10 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Back-pressure:
  - Stimulus: stream 0xA,0xB,0xC; set out_ready=0 for 3 cycles while 0xA is on the output.
  - Required: 0xB is held in skid; in_ready=0 for the 3 stall cycles; stall_cnt=3; after release the output is 0xA,0xB,0xC with no loss or duplicate.
- Flush:
  - Stimulus: state TWO with in_ctrl=8'hFF, then flush=1 together with in_valid=1 carrying 0x55.
  - Required: next cycle out_valid=0, out_ctrl=0, 0x55 never appears on the output, in_ready=1.
- SKID=0 mode:
  - Stimulus: out_ready toggles 1/0 every cycle.
  - Required: in_ready equals out_ready | !out_valid in the same cycle; order is preserved.
- Saturation:
  - Stimulus: CNT_W=4, out_valid held with out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15.
